// File: rtl/sync_updown_counter_n_pkg.sv
// Shared constants and helpers for the up/down modulo counter family.
// Direction/mode encodings and the load clamping rule live here.
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Values beyond the count range load as the top of the range.
    function automatic logic [63:0] clamp_load(input logic [63:0] val, input logic [63:0] modulus);
        return (val >= modulus) ? (modulus - 64'd1) : val;
    endfunction

endpackage

// File: rtl/sync_updown_counter_n_if.sv
// Control/status bundle of sync_updown_counter_n; master drives controls, slave is the counter.
interface sync_updown_counter_n_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr_ovf;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             ovf;

    modport master (
        output en, up, load, load_val, clr_ovf,
        input  count, tc, wrap, ovf
    );

    modport slave (
        input  en, up, load, load_val, clr_ovf,
        output count, tc, wrap, ovf
    );
endinterface

// File: rtl/sync_updown_counter_n_jk_toggle_cell.sv
// One counter bit: JK flop with synchronous active-low clear and a parallel-load override.
module jk_toggle_cell (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    input  logic ld,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= 1'b0;
        end else if (ld) begin
            q <= d;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/sync_updown_counter_n.sv
// Parametrised up/down modulo counter built from JK toggle cells, with load,
// wrap-or-saturate range ends, a cascadable terminal count and wrap/overflow status.
module sync_updown_counter_n
    import counter_pkg::*;
#(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter logic            SATURATE = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    sync_updown_counter_n_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] up_chain;
    logic [WIDTH-1:0] dn_chain;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] cell_d;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] end_value;
    logic             at_end;
    logic             step;
    logic             end_step;
    logic             cell_ld;
    logic             wrap_reg;
    logic             ovf_reg;

    assign step     = bus.en & ~bus.load;
    assign at_end   = (bus.up == DIR_UP) ? (count_reg == MAX_VAL) : (count_reg == '0);
    assign end_step = step & at_end;

    assign load_clamped = WIDTH'(clamp_load(64'(bus.load_val), 64'(MODULUS)));

    // At a range end the toggle chain is bypassed: the cells load either the
    // opposite end (wrap) or their own value (hold).
    assign end_value = (SATURATE == MODE_SAT)   ? count_reg :
                       (bus.up == DIR_DOWN)     ? MAX_VAL   : '0;
    assign cell_ld   = bus.load | end_step;
    assign cell_d    = bus.load ? load_clamped : end_value;

    // Bit i toggles when all lower bits are 1 (counting up) or all 0 (counting down).
    assign up_chain[0] = 1'b1;
    assign dn_chain[0] = 1'b1;

    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_chain
            assign up_chain[gi] = up_chain[gi-1] &  count_reg[gi-1];
            assign dn_chain[gi] = dn_chain[gi-1] & ~count_reg[gi-1];
        end

        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            assign toggle[gi] = step & ((bus.up == DIR_UP) ? up_chain[gi] : dn_chain[gi]);

            jk_toggle_cell u_cell (
                .clk   (clk),
                .reset (reset),
                .j     (toggle[gi]),
                .k     (toggle[gi]),
                .ld    (cell_ld),
                .d     (cell_d[gi]),
                .q     (count_reg[gi])
            );
        end
    endgenerate

    // A range-end step sets overflow even if clr_ovf arrives on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wrap_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            wrap_reg <= end_step & (SATURATE == MODE_WRAP);
            if (end_step) begin
                ovf_reg <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    assign bus.count = count_reg;
    assign bus.tc    = end_step;
    assign bus.wrap  = wrap_reg;
    assign bus.ovf   = ovf_reg;

endmodule

// File: tb/tb_sync_updown_counter_n.sv
// Self-checking bench: five counter configurations share one stimulus stream and
// are compared every cycle against an arithmetic reference model, plus vectors and sequences.
module tb_sync_updown_counter_n;

    localparam int N = 5;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       ld;
    logic       clr;
    logic [7:0] lv;

    int checks = 0;
    int errors = 0;

    // Configurations: {default}, {mod 10 wrap}, {mod 10 saturate}, {mod 2}, {8 bit, mod 256}
    int unsigned mods [N];
    int unsigned wds  [N];
    bit          sats [N];

    int unsigned mc [N];
    bit          mw [N];
    bit          mo [N];

    logic [7:0] cnt_a  [N];
    logic       tc_a   [N];
    logic       wrap_a [N];
    logic       ovf_a  [N];

    sync_updown_counter_n_if #(.WIDTH(4)) if0 ();
    sync_updown_counter_n_if #(.WIDTH(4)) if1 ();
    sync_updown_counter_n_if #(.WIDTH(4)) if2 ();
    sync_updown_counter_n_if #(.WIDTH(2)) if3 ();
    sync_updown_counter_n_if #(.WIDTH(8)) if4 ();

    assign if0.en = en; assign if0.up = up; assign if0.load = ld; assign if0.clr_ovf = clr; assign if0.load_val = lv[3:0];
    assign if1.en = en; assign if1.up = up; assign if1.load = ld; assign if1.clr_ovf = clr; assign if1.load_val = lv[3:0];
    assign if2.en = en; assign if2.up = up; assign if2.load = ld; assign if2.clr_ovf = clr; assign if2.load_val = lv[3:0];
    assign if3.en = en; assign if3.up = up; assign if3.load = ld; assign if3.clr_ovf = clr; assign if3.load_val = lv[1:0];
    assign if4.en = en; assign if4.up = up; assign if4.load = ld; assign if4.clr_ovf = clr; assign if4.load_val = lv;

    assign cnt_a[0] = 8'(if0.count); assign tc_a[0] = if0.tc; assign wrap_a[0] = if0.wrap; assign ovf_a[0] = if0.ovf;
    assign cnt_a[1] = 8'(if1.count); assign tc_a[1] = if1.tc; assign wrap_a[1] = if1.wrap; assign ovf_a[1] = if1.ovf;
    assign cnt_a[2] = 8'(if2.count); assign tc_a[2] = if2.tc; assign wrap_a[2] = if2.wrap; assign ovf_a[2] = if2.ovf;
    assign cnt_a[3] = 8'(if3.count); assign tc_a[3] = if3.tc; assign wrap_a[3] = if3.wrap; assign ovf_a[3] = if3.ovf;
    assign cnt_a[4] = if4.count;     assign tc_a[4] = if4.tc; assign wrap_a[4] = if4.wrap; assign ovf_a[4] = if4.ovf;

    sync_updown_counter_n #(.WIDTH(4), .MODULUS(16),  .SATURATE(1'b0)) u0 (.clk(clk), .reset(rst), .bus(if0));
    sync_updown_counter_n #(.WIDTH(4), .MODULUS(10),  .SATURATE(1'b0)) u1 (.clk(clk), .reset(rst), .bus(if1));
    sync_updown_counter_n #(.WIDTH(4), .MODULUS(10),  .SATURATE(1'b1)) u2 (.clk(clk), .reset(rst), .bus(if2));
    sync_updown_counter_n #(.WIDTH(2), .MODULUS(2),   .SATURATE(1'b0)) u3 (.clk(clk), .reset(rst), .bus(if3));
    sync_updown_counter_n #(.WIDTH(8), .MODULUS(256), .SATURATE(1'b0)) u4 (.clk(clk), .reset(rst), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst, en, up, ld;
        logic [7:0] lv;
        bit         clr;
        bit         e_tc;
        logic [3:0] e_cnt;
        bit         e_wrap, e_ovf;
    } vec_t;

    vec_t tbl [25];

    function automatic vec_t mk(bit r, bit e, bit u, bit l, logic [7:0] v, bit c,
                                bit t, logic [3:0] cnt, bit w, bit o);
        vec_t x;
        x.rst = r; x.en = e; x.up = u; x.ld = l; x.lv = v; x.clr = c;
        x.e_tc = t; x.e_cnt = cnt; x.e_wrap = w; x.e_ovf = o;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input bit r, input bit e, input bit u, input bit l,
                         input logic [7:0] v, input bit c);
        rst = r; en = e; up = u; ld = l; lv = v; clr = c;
    endtask

    // Reference: the count lives in 0..M-1; stepping is modular arithmetic,
    // and a step past either end is an overflow event.
    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            int unsigned m = mods[i];
            int unsigned v = int'(lv) % (1 << wds[i]);
            bit          ev;
            int unsigned nx;
            if (!rst) begin
                mc[i] = 0; mw[i] = 0; mo[i] = 0;
            end else if (ld) begin
                mc[i] = (v >= m) ? m - 1 : v;
                mw[i] = 0;
                if (clr) mo[i] = 0;
            end else if (en) begin
                ev = up ? (mc[i] + 1 == m) : (mc[i] == 0);
                nx = up ? (mc[i] + 1) % m : (mc[i] + m - 1) % m;
                mc[i] = (ev && sats[i]) ? mc[i] : nx;
                mw[i] = ev && !sats[i];
                if (ev) mo[i] = 1;
                else if (clr) mo[i] = 0;
            end else begin
                mw[i] = 0;
                if (clr) mo[i] = 0;
            end
        end
    endtask

    task automatic cycle(input bit do_chk);
        #1;
        if (do_chk) begin
            for (int i = 0; i < N; i++) begin
                bit t = en && !ld && (up ? (mc[i] + 1 == mods[i]) : (mc[i] == 0));
                chk($sformatf("u%0d.tc", i), 32'(tc_a[i]), 32'(t));
            end
        end
        @(posedge clk);
        model_step();
        #1;
        if (do_chk) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("u%0d.count", i), 32'(cnt_a[i]), mc[i]);
                chk($sformatf("u%0d.wrap", i), 32'(wrap_a[i]), 32'(mw[i]));
                chk($sformatf("u%0d.ovf", i), 32'(ovf_a[i]), 32'(mo[i]));
            end
        end
        $display("cyc rst=%0b en=%0b up=%0b ld=%0b lv=%0d clr=%0b -> cnt %0d %0d %0d %0d %0d",
                 rst, en, up, ld, lv, clr, cnt_a[0], cnt_a[1], cnt_a[2], cnt_a[3], cnt_a[4]);
    endtask

    initial begin
        mods = '{16, 10, 10, 2, 256};
        wds  = '{4, 4, 4, 2, 8};
        sats = '{0, 0, 1, 0, 0};
        foreach (mc[i]) begin mc[i] = 0; mw[i] = 0; mo[i] = 0; end

        // Default-configuration vectors: reset, 17 up steps, hold, down wrap, clear, load.
        tbl[0] = mk(0, 0, 0, 0, 8'd0, 0, 0, 4'd0, 0, 0);
        for (int k = 0; k < 17; k++)
            tbl[1 + k] = mk(1, 1, 1, 0, 8'd0, 0, (k == 15), 4'((k + 1) % 16), (k == 15), (k >= 15));
        tbl[18] = mk(1, 0, 1, 0, 8'd0, 0, 0, 4'd1,  0, 1);
        tbl[19] = mk(1, 1, 0, 0, 8'd0, 0, 0, 4'd0,  0, 1);
        tbl[20] = mk(1, 1, 0, 0, 8'd0, 0, 1, 4'd15, 1, 1);
        tbl[21] = mk(1, 0, 0, 0, 8'd0, 1, 0, 4'd15, 0, 0);
        tbl[22] = mk(1, 1, 1, 1, 8'd5, 0, 0, 4'd5,  0, 0);
        tbl[23] = mk(1, 1, 1, 1, 8'd2, 0, 0, 4'd2,  0, 0);
        tbl[24] = mk(0, 1, 1, 1, 8'd9, 0, 0, 4'd0,  0, 0);

        apply(0, 0, 0, 0, 8'd0, 0);
        cycle(0);

        for (int r = 0; r < 25; r++) begin
            apply(tbl[r].rst, tbl[r].en, tbl[r].up, tbl[r].ld, tbl[r].lv, tbl[r].clr);
            #1;
            chk($sformatf("vec%0d.tc", r), 32'(tc_a[0]), 32'(tbl[r].e_tc));
            cycle(1);
            chk($sformatf("vec%0d.count", r), 32'(cnt_a[0]), 32'(tbl[r].e_cnt));
            chk($sformatf("vec%0d.wrap", r), 32'(wrap_a[0]), 32'(tbl[r].e_wrap));
            chk($sformatf("vec%0d.ovf", r), 32'(ovf_a[0]), 32'(tbl[r].e_ovf));
        end

        // Modulus 10 counting down from reset, then an out-of-range load.
        apply(1, 1, 0, 0, 8'd0, 0); cycle(1);
        chk("m10.down_wrap.count", 32'(cnt_a[1]), 32'd9);
        chk("m10.down_wrap.wrap", 32'(wrap_a[1]), 32'd1);
        cycle(1);
        chk("m10.down.count", 32'(cnt_a[1]), 32'd8);
        chk("m10.down.wrap", 32'(wrap_a[1]), 32'd0);
        apply(1, 1, 0, 1, 8'd12, 0); cycle(1);
        chk("m10.clamp.count", 32'(cnt_a[1]), 32'd9);
        chk("m10.clamp.ovf", 32'(ovf_a[1]), 32'd1);

        // Saturating modulus 10: load 8, push up past the top, then step down.
        apply(0, 0, 0, 0, 8'd0, 0); cycle(1);
        apply(1, 0, 0, 1, 8'd8, 0); cycle(1);
        chk("sat.load.count", 32'(cnt_a[2]), 32'd8);
        apply(1, 1, 1, 0, 8'd0, 0);
        for (int k = 0; k < 4; k++) begin
            cycle(1);
            chk($sformatf("sat.up%0d.count", k), 32'(cnt_a[2]), 32'd9);
            chk($sformatf("sat.up%0d.wrap", k), 32'(wrap_a[2]), 32'd0);
        end
        chk("sat.ovf", 32'(ovf_a[2]), 32'd1);
        apply(1, 1, 0, 0, 8'd0, 0); cycle(1);
        chk("sat.down.count", 32'(cnt_a[2]), 32'd8);

        // Clear and wrap on the same edge: the set wins.
        apply(0, 0, 0, 0, 8'd0, 0); cycle(1);
        apply(1, 0, 0, 1, 8'd15, 0); cycle(1);
        chk("clrwrap.pre_ovf", 32'(ovf_a[0]), 32'd0);
        apply(1, 1, 1, 0, 8'd0, 1);
        #1;
        chk("clrwrap.tc", 32'(tc_a[0]), 32'd1);
        cycle(1);
        chk("clrwrap.count", 32'(cnt_a[0]), 32'd0);
        chk("clrwrap.wrap", 32'(wrap_a[0]), 32'd1);
        chk("clrwrap.ovf", 32'(ovf_a[0]), 32'd1);

        // Reset while counting with en and load both high, then resume.
        apply(0, 0, 0, 0, 8'd0, 0); cycle(1);
        apply(1, 1, 1, 0, 8'd0, 0);
        for (int k = 0; k < 7; k++) cycle(1);
        chk("midrst.pre.count", 32'(cnt_a[0]), 32'd7);
        apply(0, 1, 1, 1, 8'd3, 0); cycle(1);
        chk("midrst.count", 32'(cnt_a[0]), 32'd0);
        chk("midrst.wrap", 32'(wrap_a[0]), 32'd0);
        chk("midrst.ovf", 32'(ovf_a[0]), 32'd0);
        apply(1, 1, 1, 0, 8'd0, 0); cycle(1);
        chk("midrst.resume.count", 32'(cnt_a[0]), 32'd1);

        // Modulus 2 toggling, then 8-bit natural rollover.
        apply(0, 0, 0, 0, 8'd0, 0); cycle(1);
        apply(1, 1, 1, 0, 8'd0, 0);
        for (int k = 0; k < 4; k++) begin
            cycle(1);
            chk($sformatf("m2.step%0d.count", k), 32'(cnt_a[3]), 32'((k + 1) % 2));
            chk($sformatf("m2.step%0d.wrap", k), 32'(wrap_a[3]), 32'(k % 2));
        end
        apply(1, 0, 0, 1, 8'd255, 0); cycle(1);
        chk("w8.load.count", 32'(cnt_a[4]), 32'd255);
        apply(1, 1, 1, 0, 8'd0, 0); cycle(1);
        chk("w8.roll.count", 32'(cnt_a[4]), 32'd0);
        chk("w8.roll.wrap", 32'(wrap_a[4]), 32'd1);

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            bit r_ld;
            r_ld = ($urandom_range(7) == 0);
            apply(($urandom_range(31) != 0), ($urandom_range(3) != 0), 1'($urandom_range(1)),
                  r_ld, 8'($urandom_range(255)), (!r_ld && ($urandom_range(7) == 0)));
            cycle(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
